mem_bus_arbiter: RTL and testbench

- Arbitrates one shared memory bus between the fetch stage (instruction port, read-only) and the memory stage (data port, read/write).
- Sits between the pipeline's ibus/dbus request points and the single external bus.
- Serialises transactions and latches request fields at grant time.
- Routes each bus response back to the requester that owns the transaction.

---
 rtl/mem_bus_arbiter_if.sv | 64 ++++++
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Bundles every signal around the memory-bus arbiter: the instruction
// request point (i_*), the data request point (d_*), the shared external
// bus (bus_*) and the busy flag.
//
// Modports:
//   master : the arbiter's view. It masters the external bus and answers
//            the two pipeline requesters.
//   slave  : the environment's view. This is the pipeline plus the memory
//            behind the bus, i.e. everything the arbiter talks to.
//
// Parameters: ADDR_W (address width), DATA_W (data width, strobe = DATA_W/8).
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // instruction port (read-only)
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_data_ok;
    logic [DATA_W-1:0] i_rdata;

    // data port (read/write)
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_strobe;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;

    // shared external bus
    logic              bus_req;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [STRB_W-1:0] bus_strobe;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_data_ok;

    logic              busy;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_wr, d_addr, d_wdata, d_strobe,
        input  bus_rdata, bus_data_ok,
        output i_data_ok, i_rdata,
        output d_data_ok, d_rdata,
        output bus_req, bus_wr, bus_addr, bus_wdata, bus_strobe,
        output busy
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_wr, d_addr, d_wdata, d_strobe,
        output bus_rdata, bus_data_ok,
        input  i_data_ok, i_rdata,
        input  d_data_ok, d_rdata,
        input  bus_req, bus_wr, bus_addr, bus_wdata, bus_strobe,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external memory bus between the fetch stage (instruction
// port, reads only) and the memory stage (data port, reads and writes).
// It runs one transaction at a time. Request fields are latched into the
// bus registers when the grant is made. The single completion pulse is
// routed back to whichever port owns the transaction.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bif   : mem_bus_arbiter_if.master. It carries i_*, d_*, bus_* and busy.
//           The widths come from the interface parameters ADDR_W and DATA_W.
//
// Build option:
//   MEM_BUS_ARB_DPRIO_EN
//     Defined: strict data priority. After a data transaction completes,
//     the arbiter drops back to IDLE. A data request raised in the following
//     cycle then wins over a waiting fetch, so fetch may starve.
//     Undefined (default): after completion the grant passes to the other
//     port if it is waiting, so the two ports alternate under contention.
module mem_bus_arbiter (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.master  bif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   load_i;
    logic   load_d;
    logic   done;

    // bus_data_ok only means something while a transaction is outstanding.
    assign done = (state != IDLE) && bif.bus_data_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The req level that a port shows in its own data_ok cycle is never
    // treated as a new request. So a completion never re-grants the same
    // port: it either hands over to the other port or returns to IDLE.
    always_comb begin
        state_nxt = state;
        load_i    = 1'b0;
        load_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bif.d_req) begin
                    state_nxt = GNT_D;
                    load_d    = 1'b1;
                end else if (bif.i_req) begin
                    state_nxt = GNT_I;
                    load_i    = 1'b1;
                end
            end
            GNT_I: begin
                if (done) begin
                    if (bif.d_req) begin
                        state_nxt = GNT_D;
                        load_d    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GNT_D: begin
                if (done) begin
`ifdef MEM_BUS_ARB_DPRIO_EN
                    // Wait one cycle in IDLE so that a data re-request can
                    // be seen and win over fetch.
                    state_nxt = IDLE;
`else
                    if (bif.i_req) begin
                        state_nxt = GNT_I;
                        load_i    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The bus fields are captured at grant time and then hold still,
    // whatever the requester does with its inputs afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bif.bus_wr     <= 1'b0;
            bif.bus_addr   <= '0;
            bif.bus_wdata  <= '0;
            bif.bus_strobe <= '0;
        end else if (load_d) begin
            bif.bus_wr     <= bif.d_wr;
            bif.bus_addr   <= bif.d_addr;
            bif.bus_wdata  <= bif.d_wdata;
            bif.bus_strobe <= bif.d_wr ? bif.d_strobe : '0;
        end else if (load_i) begin
            bif.bus_wr     <= 1'b0;
            bif.bus_addr   <= bif.i_addr;
            bif.bus_wdata  <= '0;
            bif.bus_strobe <= '0;
        end
    end

    assign bif.bus_req   = (state != IDLE);
    assign bif.busy      = (state != IDLE);

    // The completion is passed straight through to the owner in the same cycle.
    assign bif.i_data_ok = (state == GNT_I) && bif.bus_data_ok;
    assign bif.d_data_ok = (state == GNT_D) && bif.bus_data_ok;
    assign bif.i_rdata   = bif.bus_rdata;
    assign bif.d_rdata   = bif.bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed scenarios for reset, fetch, write-then-switch, contention order,
// requester drop and mid-transaction reset. After them comes a randomised
// run against a behavioural model of two requesters and a word memory.
// Instruction addresses live at 0x1xxxxxxx and data addresses at
// 0x2xxxxxxx, so the owner of a bus transaction can be told from its address.
module tb_mem_bus_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return rom(a);
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        logic [31:0] v;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        mem[a] = v;
    endfunction

    function automatic int region(input logic [31:0] a);
        if (a[31:28] == 4'h1) return 1;
        if (a[31:28] == 4'h2) return 2;
        return 0;
    endfunction

    task automatic idle_inputs();
        bif.i_req       = 1'b0;
        bif.i_addr      = '0;
        bif.d_req       = 1'b0;
        bif.d_wr        = 1'b0;
        bif.d_addr      = '0;
        bif.d_wdata     = '0;
        bif.d_strobe    = '0;
        bif.bus_rdata   = '0;
        bif.bus_data_ok = 1'b0;
    endtask

    // Leaves the caller just after a falling edge, with reset released.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bif.i_req = 1'b1; bif.i_addr = 32'h1000_0000;
        bif.d_req = 1'b1; bif.d_wr = 1'b0; bif.d_addr = 32'h8000_0040; bif.d_strobe = 4'hF;
        @(negedge clk);
        bif.bus_data_ok = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bif.bus_req !== 1'b0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle bus_req=%b busy=%b expected 0 0", bif.bus_req, bif.busy);
        end
        checks++;
        if (bif.i_data_ok !== 1'b0 || bif.d_data_ok !== 1'b0) begin
            errors++; $display("FAIL reset_data_ok i=%b d=%b expected 0 0", bif.i_data_ok, bif.d_data_ok);
        end
        checks++;
        if (bif.bus_addr !== 32'h0 || bif.bus_wr !== 1'b0 || bif.bus_strobe !== 4'h0) begin
            errors++; $display("FAIL reset_fields addr=%h wr=%b strb=%h expected 0", bif.bus_addr, bif.bus_wr, bif.bus_strobe);
        end
        bif.bus_data_ok = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h8000_0040 || bif.bus_strobe !== 4'h0 || bif.busy !== 1'b1) begin
            errors++; $display("FAIL reset_release_grant req=%b addr=%h strb=%h busy=%b expected 1 80000040 0 1",
                               bif.bus_req, bif.bus_addr, bif.bus_strobe, bif.busy);
        end
    endtask

    task automatic test_ifetch();
        do_reset();
        bif.i_req = 1'b1; bif.i_addr = 32'hBFC0_0000;
        #1;
        checks++;
        if (bif.bus_req !== 1'b0) begin
            errors++; $display("FAIL ifetch_no_early_req bus_req=%b expected 0", bif.bus_req);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h2402_0001; bif.i_req = 1'b0;
            end
            #1;
            checks++;
            if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'hBFC0_0000 || bif.bus_wr !== 1'b0) begin
                errors++; $display("FAIL ifetch_bus k=%0d req=%b addr=%h wr=%b expected 1 bfc00000 0",
                                   k, bif.bus_req, bif.bus_addr, bif.bus_wr);
            end
            checks++;
            if (bif.i_data_ok !== (k == 2) || bif.d_data_ok !== 1'b0) begin
                errors++; $display("FAIL ifetch_ok k=%0d i_ok=%b d_ok=%b expected %b 0",
                                   k, bif.i_data_ok, bif.d_data_ok, (k == 2));
            end
        end
        checks++;
        if (bif.i_rdata !== 32'h2402_0001) begin
            errors++; $display("FAIL ifetch_rdata got=%h expected 24020001", bif.i_rdata);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (bif.bus_req !== 1'b0 || bif.busy !== 1'b0 || bif.i_data_ok !== 1'b0) begin
            errors++; $display("FAIL ifetch_return_idle req=%b busy=%b i_ok=%b expected 0 0 0",
                               bif.bus_req, bif.busy, bif.i_data_ok);
        end
    endtask

    task automatic test_dwrite_switch();
        do_reset();
        bif.i_req = 1'b1; bif.i_addr = 32'hBFC0_0004;
        bif.d_req = 1'b1; bif.d_wr = 1'b1; bif.d_addr = 32'h8000_0010;
        bif.d_wdata = 32'hDEAD_BEEF; bif.d_strobe = 4'hF;
        @(negedge clk); #1;
        checks++;
        if (bif.bus_req !== 1'b1 || bif.bus_wr !== 1'b1 || bif.bus_addr !== 32'h8000_0010 ||
            bif.bus_wdata !== 32'hDEAD_BEEF || bif.bus_strobe !== 4'hF) begin
            errors++; $display("FAIL dwrite_fields req=%b wr=%b addr=%h wdata=%h strb=%h expected 1 1 80000010 deadbeef f",
                               bif.bus_req, bif.bus_wr, bif.bus_addr, bif.bus_wdata, bif.bus_strobe);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h0; bif.d_req = 1'b0;
        #1;
        checks++;
        if (bif.d_data_ok !== 1'b1 || bif.i_data_ok !== 1'b0) begin
            errors++; $display("FAIL dwrite_ok d_ok=%b i_ok=%b expected 1 0", bif.d_data_ok, bif.i_data_ok);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b0;
        #1;
`ifdef MEM_BUS_ARB_DPRIO_EN
        checks++;
        if (bif.bus_req !== 1'b0) begin
            errors++; $display("FAIL dprio_gap bus_req=%b expected 0", bif.bus_req);
        end
        @(negedge clk); #1;
`endif
        checks++;
        if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'hBFC0_0004 || bif.bus_wr !== 1'b0 || bif.bus_strobe !== 4'h0) begin
            errors++; $display("FAIL switch_to_i req=%b addr=%h wr=%b strb=%h expected 1 bfc00004 0 0",
                               bif.bus_req, bif.bus_addr, bif.bus_wr, bif.bus_strobe);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h1234_5678; bif.i_req = 1'b0;
        #1;
        checks++;
        if (bif.i_data_ok !== 1'b1 || bif.i_rdata !== 32'h1234_5678 || bif.d_data_ok !== 1'b0) begin
            errors++; $display("FAIL switch_i_ok i_ok=%b rdata=%h d_ok=%b expected 1 12345678 0",
                               bif.i_data_ok, bif.i_rdata, bif.d_data_ok);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b0;
    endtask

    task automatic test_alternate();
        string got;
        string exp;
        int    n;
        got = ""; n = 0;
`ifdef MEM_BUS_ARB_DPRIO_EN
        exp = "DDDD";
`else
        exp = "DIDI";
`endif
        do_reset();
        bif.i_req = 1'b1; bif.i_addr = 32'h1000_0100;
        bif.d_req = 1'b1; bif.d_wr = 1'b0; bif.d_addr = 32'h2000_0100;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            bif.bus_data_ok = bif.bus_req;
            bif.bus_rdata   = $urandom;
            #1;
            if (bif.d_data_ok === 1'b1) begin got = {got, "D"}; n++; end
            if (bif.i_data_ok === 1'b1) begin got = {got, "I"}; n++; end
        end
        checks++;
        if (got != exp) begin
            errors++; $display("FAIL grant_order got=%s expected %s", got, exp);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_drop_req();
        do_reset();
        bif.d_req = 1'b1; bif.d_wr = 1'b1; bif.d_addr = 32'h8000_0010;
        bif.d_wdata = 32'h1234_5678; bif.d_strobe = 4'h3;
        @(negedge clk);
        bif.d_req = 1'b0; bif.d_addr = 32'h0; bif.d_wdata = 32'h0; bif.d_strobe = 4'h0;
        #1;
        checks++;
        if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h8000_0010 || bif.bus_wdata !== 32'h1234_5678 || bif.bus_strobe !== 4'h3) begin
            errors++; $display("FAIL drop_latched req=%b addr=%h wdata=%h strb=%h expected 1 80000010 12345678 3",
                               bif.bus_req, bif.bus_addr, bif.bus_wdata, bif.bus_strobe);
        end
        @(negedge clk); #1;
        checks++;
        if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h8000_0010) begin
            errors++; $display("FAIL drop_hold req=%b addr=%h expected 1 80000010", bif.bus_req, bif.bus_addr);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b1;
        #1;
        checks++;
        if (bif.d_data_ok !== 1'b1) begin
            errors++; $display("FAIL drop_completes d_ok=%b expected 1", bif.d_data_ok);
        end
        @(negedge clk);
        bif.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (bif.busy !== 1'b0) begin
            errors++; $display("FAIL drop_idle busy=%b expected 0", bif.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bif.i_req = 1'b1; bif.i_addr = 32'h1000_0200;
        @(negedge clk); #1;
        checks++;
        if (bif.busy !== 1'b1) begin
            errors++; $display("FAIL mid_granted busy=%b expected 1", bif.busy);
        end
        #2;
        reset = 1'b1; bif.bus_data_ok = 1'b1;
        #1;
        checks++;
        if (bif.bus_req !== 1'b0 || bif.busy !== 1'b0 || bif.i_data_ok !== 1'b0) begin
            errors++; $display("FAIL async_reset req=%b busy=%b i_ok=%b expected 0 0 0",
                               bif.bus_req, bif.busy, bif.i_data_ok);
        end
        @(negedge clk);
        reset = 1'b0; bif.i_req = 1'b0; bif.bus_data_ok = 1'b1;
        #1;
        checks++;
        if (bif.i_data_ok !== 1'b0 || bif.d_data_ok !== 1'b0) begin
            errors++; $display("FAIL spurious_ok i_ok=%b d_ok=%b expected 0 0", bif.i_data_ok, bif.d_data_ok);
        end
        @(negedge clk); #1;
        checks++;
        if (bif.bus_req !== 1'b0 || bif.busy !== 1'b0) begin
            errors++; $display("FAIL spurious_idle req=%b busy=%b expected 0 0", bif.bus_req, bif.busy);
        end
        bif.bus_data_ok = 1'b0;
    endtask

    // ---------------- randomised run ----------------
    task automatic test_random();
        logic        i_pend, d_pend, d_wr_c, rsp_act, ok_now;
        logic        prev_bus_req, prev_i_req, prev_d_req, exp_i, exp_d;
        logic [31:0] i_a, d_a, d_wd, exp_rd;
        logic [3:0]  d_st, exp_st;
        int          rsp_wait, owner, prev_done, i_age, d_age, max_i_age, max_d_age, n_done;
        i_pend = 0; d_pend = 0; d_wr_c = 0; rsp_act = 0; ok_now = 0;
        prev_bus_req = 0; prev_i_req = 0; prev_d_req = 0;
        i_a = 32'h1000_0000; d_a = 32'h2000_0000; d_wd = 0; d_st = 0;
        rsp_wait = 0; owner = 0; prev_done = 0;
        i_age = 0; d_age = 0; max_i_age = 0; max_d_age = 0; n_done = 0;
        mem.delete();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            // A request seen in IDLE is granted on the next edge, data first.
            if (!prev_bus_req && (prev_i_req || prev_d_req)) begin
                checks++;
                if (bif.bus_req !== 1'b1 || bif.bus_addr !== (prev_d_req ? d_a : i_a)) begin
                    errors++; $display("FAIL idle_grant cyc=%0d req=%b addr=%h expected 1 %h",
                                       cyc, bif.bus_req, bif.bus_addr, prev_d_req ? d_a : i_a);
                end
            end
            // A transaction that follows a completion without a gap goes to the other port.
            if (prev_done != 0 && bif.bus_req === 1'b1) begin
                checks++;
                if (region(bif.bus_addr) == prev_done) begin
                    errors++; $display("FAIL back_to_back cyc=%0d port=%0d repeated", cyc, prev_done);
                end
            end
            // bus responder
            ok_now = 1'b0;
            if (bif.bus_req === 1'b1) begin
                if (!rsp_act) begin
                    rsp_act  = 1'b1;
                    owner    = region(bif.bus_addr);
                    rsp_wait = int'($urandom_range(0, 3));
                    checks++;
                    exp_st = d_wr_c ? d_st : 4'h0;
                    if (owner == 1) begin
                        if (!i_pend || bif.bus_wr !== 1'b0 || bif.bus_addr !== i_a || bif.bus_strobe !== 4'h0) begin
                            errors++; $display("FAIL i_fields cyc=%0d pend=%b wr=%b addr=%h strb=%h expected 1 0 %h 0",
                                               cyc, i_pend, bif.bus_wr, bif.bus_addr, bif.bus_strobe, i_a);
                        end
                    end else if (owner == 2) begin
                        if (!d_pend || bif.bus_wr !== d_wr_c || bif.bus_addr !== d_a || bif.bus_strobe !== exp_st ||
                            (d_wr_c && bif.bus_wdata !== d_wd)) begin
                            errors++; $display("FAIL d_fields cyc=%0d pend=%b wr=%b addr=%h wdata=%h strb=%h expected 1 %b %h %h %h",
                                               cyc, d_pend, bif.bus_wr, bif.bus_addr, bif.bus_wdata, bif.bus_strobe,
                                               d_wr_c, d_a, d_wd, exp_st);
                        end
                    end else begin
                        errors++; $display("FAIL bus_owner cyc=%0d addr=%h expected an i or d address", cyc, bif.bus_addr);
                    end
                end
                if (rsp_wait == 0) begin
                    ok_now = 1'b1;
                    bif.bus_data_ok = 1'b1;
                    bif.bus_rdata   = mem_rd(bif.bus_addr);
                end else begin
                    rsp_wait--;
                    bif.bus_data_ok = 1'b0;
                    bif.bus_rdata   = $urandom;
                end
            end else begin
                bif.bus_data_ok = ($urandom_range(0, 7) == 0);
                bif.bus_rdata   = $urandom;
            end
            // requesters: a new request only once the previous one is done
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1; i_age = 0;
                i_a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_age = 0;
                d_wr_c = 1'($urandom_range(0, 1));
                d_a    = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2);
                d_wd   = $urandom;
                d_st   = 4'($urandom_range(1, 15));
            end
            bif.i_req = i_pend; bif.i_addr = i_a;
            bif.d_req = d_pend; bif.d_wr = d_wr_c; bif.d_addr = d_a;
            bif.d_wdata = d_wd; bif.d_strobe = d_st;
            #1;
            exp_i = ok_now && (owner == 1);
            exp_d = ok_now && (owner == 2);
            checks++;
            if (bif.i_data_ok !== exp_i || bif.d_data_ok !== exp_d) begin
                errors++; $display("FAIL data_ok_route cyc=%0d i_ok=%b d_ok=%b expected %b %b",
                                   cyc, bif.i_data_ok, bif.d_data_ok, exp_i, exp_d);
            end
            if (exp_i) begin
                checks++;
                if (bif.i_rdata !== rom(i_a)) begin
                    errors++; $display("FAIL i_rdata cyc=%0d got=%h expected %h", cyc, bif.i_rdata, rom(i_a));
                end
            end
            if (exp_d && !d_wr_c) begin
                exp_rd = mem_rd(d_a);
                checks++;
                if (bif.d_rdata !== exp_rd) begin
                    errors++; $display("FAIL d_rdata cyc=%0d got=%h expected %h", cyc, bif.d_rdata, exp_rd);
                end
            end
            if (ok_now) begin
                if (owner == 2 && d_wr_c) mem_wr(d_a, d_wd, d_st);
                if (owner == 1) i_pend = 1'b0;
                if (owner == 2) d_pend = 1'b0;
                rsp_act = 1'b0; prev_done = owner; n_done++;
            end else begin
                prev_done = 0;
            end
            prev_bus_req = bif.bus_req; prev_i_req = bif.i_req; prev_d_req = bif.d_req;
            if (i_pend) begin i_age++; if (i_age > max_i_age) max_i_age = i_age; end
            if (d_pend) begin d_age++; if (d_age > max_d_age) max_d_age = d_age; end
        end
        checks++;
        if (n_done < 50) begin
            errors++; $display("FAIL throughput completions=%0d expected at least 50", n_done);
        end
        checks++;
        if (max_d_age > 20) begin
            errors++; $display("FAIL d_wait max=%0d expected at most 20", max_d_age);
        end
`ifndef MEM_BUS_ARB_DPRIO_EN
        checks++;
        if (max_i_age > 20) begin
            errors++; $display("FAIL i_wait max=%0d expected at most 20", max_i_age);
        end
`endif
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ifetch();
        test_dwrite_switch();
        test_alternate();
        test_drop_req();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
